// File: rtl/umips_imem_loader.sv
// umips_imem_loader
//   Boot-time program loader placed in front of umips_top. Receives a framed
//   word stream (length N, N payload words, XOR checksum) over valid/ready,
//   writes the payload into instruction memory through a registered write
//   port, and holds the core in reset until the checksum has been verified.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   in_data     stream word
//   in_valid    in_data valid this cycle
//   in_ready    loader accepts a word this cycle (decoded from state only)
//   imem_we     one-cycle write pulse to instruction memory
//   imem_addr   instruction memory word address
//   imem_wdata  instruction memory write data
//   core_reset  active-high reset to umips_top; low only once verified
//   done        image loaded and verified
//   error       bad length header or checksum mismatch
//
// state | meaning
// ------+-------------------------------------------------------------
// HDR   | waiting for the length word N
// LOAD  | accepting payload words, one memory write per accepted word
// CHK   | waiting for the checksum word
// RUN   | image verified; core released (terminal until reset)
// ERR   | bad header or checksum; core held in reset (terminal)

module umips_imem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  core_reset,
  output logic                  done,
  output logic                  error
);

  // One extra bit so that N == 2**ADDR_WIDTH is representable.
  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_HDR,
    S_LOAD,
    S_CHK,
    S_RUN,
    S_ERR
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   len;
  logic [CW-1:0]   count;
  logic [DATA_WIDTH-1:0] csum;
  logic            hdr_bad;
  logic            last_word;

  // The full header word is range-checked, so junk in the upper bits is an error.
  assign hdr_bad   = (in_data == '0) || (in_data > DATA_WIDTH'(MAX_WORDS));
  assign last_word = (count == len - CW'(1));

  always_ff @(posedge clk) begin
    if (reset) state <= S_HDR;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      S_HDR: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = hdr_bad ? S_ERR : S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && last_word) state_nx = S_CHK;
      end
      S_CHK: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = (in_data == csum) ? S_RUN : S_ERR;
      end
      S_RUN:   state_nx = S_RUN;
      S_ERR:   state_nx = S_ERR;
      default: state_nx = S_HDR;
    endcase
  end

  // Write port is registered: the write for a word accepted in LOAD appears
  // the following cycle. The last write therefore coincides with the first
  // cycle of CHK, so the core cannot leave reset before it completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      len        <= '0;
      count      <= '0;
      csum       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_HDR: begin
          if (in_valid) begin
            len   <= in_data[CW-1:0];
            count <= '0;
            csum  <= '0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            imem_we    <= 1'b1;
            imem_addr  <= count[ADDR_WIDTH-1:0];
            imem_wdata <= in_data;
            count      <= count + CW'(1);
            csum       <= csum ^ in_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign done       = (state == S_RUN);
  assign error      = (state == S_ERR);
  assign core_reset = (state != S_RUN);

endmodule

// File: tb/tb_umips_imem_loader.sv
module tb_umips_imem_loader;

  logic        clk;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  int we_count = 0;

  umips_imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .MAX_WORDS(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (imem_we) we_count++;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [31:0] data;
    logic        chk;
    logic        e_rdy;
    logic        e_we;
    logic [7:0]  e_addr;
    logic [31:0] e_wdata;
    logic        e_done;
    logic        e_err;
    logic        e_crst;
  } vec_t;

  vec_t tbl[$];

  // Payload used by the nominal and bad-checksum images; checksum is the XOR.
  localparam logic [31:0] W0 = 32'h24080005;
  localparam logic [31:0] W1 = 32'h24090007;
  localparam logic [31:0] W2 = 32'h01095020;
  localparam logic [31:0] CS = 32'h01085022;

  task automatic add(input logic rst, input logic vld, input logic [31:0] data,
                     input logic chk, input logic e_rdy, input logic e_we,
                     input logic [7:0] e_addr, input logic [31:0] e_wdata,
                     input logic e_done, input logic e_err, input logic e_crst);
    vec_t v;
    v.rst = rst; v.vld = vld; v.data = data; v.chk = chk;
    v.e_rdy = e_rdy; v.e_we = e_we; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.e_done = e_done; v.e_err = e_err; v.e_crst = e_crst;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic rdy, input logic we,
                           input logic [7:0] addr, input logic [31:0] wdata,
                           input logic dn, input logic er, input logic crst);
    check({tag, ".in_ready"},   {31'd0, in_ready},   {31'd0, rdy});
    check({tag, ".imem_we"},    {31'd0, imem_we},    {31'd0, we});
    check({tag, ".imem_addr"},  {24'd0, imem_addr},  {24'd0, addr});
    check({tag, ".imem_wdata"}, imem_wdata,          wdata);
    check({tag, ".done"},       {31'd0, done},       {31'd0, dn});
    check({tag, ".error"},      {31'd0, error},      {31'd0, er});
    check({tag, ".core_reset"}, {31'd0, core_reset}, {31'd0, crst});
  endtask

  // Drive inputs for one cycle, then move to #1 after the next rising edge.
  task automatic step(input logic rst, input logic vld, input logic [31:0] data);
    reset    = rst;
    in_valid = vld;
    in_data  = data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;

    // Nominal image, then valid pulses in RUN are ignored.
    add(1, 0, 0,            0, 0, 0, 0, 0,  0, 0, 0);
    add(0, 1, 32'd3,        1, 1, 0, 0, 0,  0, 0, 1);
    add(0, 1, W0,           1, 1, 0, 0, 0,  0, 0, 1);
    add(0, 1, W1,           1, 1, 1, 0, W0, 0, 0, 1);
    add(0, 1, W2,           1, 1, 1, 1, W1, 0, 0, 1);
    add(0, 1, CS,           1, 1, 1, 2, W2, 0, 0, 1);
    add(0, 1, 32'h12345678, 1, 0, 0, 2, W2, 1, 0, 0);
    add(1, 0, 0,            1, 0, 0, 2, W2, 1, 0, 0);
    // Same payload, wrong checksum; later pulses cause no writes.
    add(0, 1, 32'd3,        1, 1, 0, 0, 0,  0, 0, 1);
    add(0, 1, W0,           1, 1, 0, 0, 0,  0, 0, 1);
    add(0, 1, W1,           1, 1, 1, 0, W0, 0, 0, 1);
    add(0, 1, W2,           1, 1, 1, 1, W1, 0, 0, 1);
    add(0, 1, 32'h0,        1, 1, 1, 2, W2, 0, 0, 1);
    add(0, 1, W0,           1, 0, 0, 2, W2, 0, 1, 1);
    add(0, 1, W1,           1, 0, 0, 2, W2, 0, 1, 1);
    add(1, 0, 0,            1, 0, 0, 2, W2, 0, 1, 1);
    // Header N=0.
    add(0, 1, 32'd0,        1, 1, 0, 0, 0,  0, 0, 1);
    add(0, 1, W0,           1, 0, 0, 0, 0,  0, 1, 1);
    add(1, 0, 0,            1, 0, 0, 0, 0,  0, 1, 1);
    // Header N=257.
    add(0, 1, 32'd257,      1, 1, 0, 0, 0,  0, 0, 1);
    add(0, 1, W0,           1, 0, 0, 0, 0,  0, 1, 1);
    add(1, 0, 0,            1, 0, 0, 0, 0,  0, 1, 1);
    // Header N=256 is legal.
    add(0, 1, 32'd256,      1, 1, 0, 0, 0,  0, 0, 1);
    add(0, 0, 0,            1, 1, 0, 0, 0,  0, 0, 1);

    @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].chk)
        check_all($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_we, tbl[i].e_addr,
                  tbl[i].e_wdata, tbl[i].e_done, tbl[i].e_err, tbl[i].e_crst);
      step(tbl[i].rst, tbl[i].vld, tbl[i].data);
    end

    // Stalled stream: N=2 with in_valid low for 3 cycles between words.
    step(1, 0, 0);
    base = we_count;
    step(0, 1, 32'd2);
    step(0, 1, 32'h11111111);
    check_all("stall_w0", 1, 1, 0, 32'h11111111, 0, 0, 1);
    step(0, 0, 32'hFFFFFFFF);
    check_all("stall_gap1", 1, 0, 0, 32'h11111111, 0, 0, 1);
    step(0, 0, 32'hFFFFFFFF);
    check_all("stall_gap2", 1, 0, 0, 32'h11111111, 0, 0, 1);
    step(0, 0, 32'hFFFFFFFF);
    check_all("stall_gap3", 1, 0, 0, 32'h11111111, 0, 0, 1);
    step(0, 1, 32'h22222222);
    check_all("stall_w1", 1, 1, 1, 32'h22222222, 0, 0, 1);
    step(0, 1, 32'h33333333);
    check_all("stall_done", 0, 0, 1, 32'h22222222, 1, 0, 0);
    check("stall_we_pulses", we_count - base, 2);

    // Reset mid-load, then a fresh single-word image.
    step(1, 0, 0);
    step(0, 1, 32'd4);
    step(0, 1, 32'hAAAA0000);
    step(0, 1, 32'hAAAA0001);
    check_all("midrst_w1", 1, 1, 1, 32'hAAAA0001, 0, 0, 1);
    step(1, 0, 0);
    check_all("midrst_after", 1, 0, 0, 32'h0, 0, 0, 1);
    step(0, 1, 32'd1);
    step(0, 1, 32'hDEADBEEF);
    check_all("midrst_new_w0", 1, 1, 0, 32'hDEADBEEF, 0, 0, 1);
    step(0, 1, 32'hDEADBEEF);
    check_all("midrst_done", 0, 0, 0, 32'hDEADBEEF, 1, 0, 0);

    // Full-size image: word i = i, XOR of 0..255 is zero.
    step(1, 0, 0);
    base = we_count;
    step(0, 1, 32'd256);
    for (int i = 0; i < 256; i++) begin
      step(0, 1, i);
      if (!imem_we || imem_addr != i[7:0] || imem_wdata != i) begin
        check($sformatf("full_w%0d.addr", i), {24'd0, imem_addr}, i);
        check($sformatf("full_w%0d.wdata", i), imem_wdata, i);
        check($sformatf("full_w%0d.we", i), {31'd0, imem_we}, 1);
      end
    end
    check("full_last_addr", {24'd0, imem_addr}, 32'd255);
    check("full_chk_ready", {31'd0, in_ready}, 1);
    check("full_not_done_yet", {31'd0, done}, 0);
    step(0, 1, 32'h0);
    check_all("full_done", 0, 0, 255, 32'd255, 1, 0, 0);
    check("full_we_pulses", we_count - base, 256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
